// File: rtl/pb_level_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, clean level and edge pulses.
// Optional auto-repeat pulse while held is built only when PB_AUTOREPEAT_EN is defined.
//
//   state  | meaning
//   IDLE   | level low, pin low
//   ARM_HI | pin went high, qualifying a rise
//   HELD   | level high, pin high
//   ARM_LO | pin went low, qualifying a fall
module pb_level_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic CLK100MHZ,
  input  logic reset_n,
  input  logic pb_raw,
  output logic lv_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rep_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM_HI = 2'd1,
    HELD   = 2'd2,
    ARM_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             lv_q, lv_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             cnt_done;

  assign cnt_done = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      lv_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= pb_raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lv_q    <= lv_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any disagreement with the armed direction aborts back to the stable state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = ARM_HI;
          cnt_d   = '0;
        end
      end
      ARM_HI: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = ARM_LO;
          cnt_d   = '0;
        end
      end
      ARM_LO: begin
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    lv_d   = (state_d == HELD) || (state_d == ARM_LO);
    rise_d = (state_q == ARM_HI) && (state_d == HELD);
    fall_d = (state_q == ARM_LO) && (state_d == IDLE);
  end

  assign lv_out     = lv_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef PB_AUTOREPEAT_EN
  // Repeat counter is sized for the longer repeat interval, independent of CNT_W.
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(REP_MAX);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              rep_first_q, rep_first_d;
  logic              rep_q, rep_d;

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_q      <= '0;
      rep_first_q <= 1'b0;
      rep_q       <= 1'b0;
    end else begin
      rcnt_q      <= rcnt_d;
      rep_first_q <= rep_first_d;
      rep_q       <= rep_d;
    end
  end

  // Counts only while HELD persists, so the entry edge and ARM_LO bounces leave it frozen.
  always_comb begin
    rcnt_d      = rcnt_q;
    rep_first_d = rep_first_q;
    rep_d       = 1'b0;
    if ((state_q == HELD) && (state_d == HELD)) begin
      if (rcnt_q == (rep_first_q ? PERIOD_LAST : DELAY_LAST)) begin
        rep_d       = 1'b1;
        rcnt_d      = '0;
        rep_first_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RCNT_W'(1);
      end
    end else if ((state_q == ARM_LO) && (state_d == IDLE)) begin
      rcnt_d      = '0;
      rep_first_d = 1'b0;
    end
  end

  assign rep_pulse = rep_q;
`else
  assign rep_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_pb_level_conditioner.sv
// Self-checking bench for pb_level_conditioner: directed scenarios plus random pin activity,
// compared every cycle against a run-length model of the debounce rules.
module tb_pb_level_conditioner;

  localparam int D      = 16;
  localparam int RDELAY = 40;
  localparam int RPER   = 10;
`ifdef PB_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic pb_raw;
  logic lv_out, rise_pulse, fall_pulse, rep_pulse;

  int checks = 0;
  int errors = 0;

  pb_level_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RDELAY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .CLK100MHZ (clk),
    .reset_n   (rst_n),
    .pb_raw    (pb_raw),
    .lv_out    (lv_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .rep_pulse (rep_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the pin reaches the decision logic two edges late; the level flips once
  // D+1 consecutive samples disagree with it; hold time counts samples that agree with a high level.
  logic p1, p2, smp;
  logic m_lv, m_rise, m_fall, m_rep;
  int   m_run, m_ticks;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 = 0; p2 = 0; m_lv = 0; m_rise = 0; m_fall = 0; m_rep = 0; m_run = 0; m_ticks = 0;
    end else begin
      logic tick;
      smp = p2;
      p2  = p1;
      p1  = pb_raw;
      m_rise = 0; m_fall = 0; m_rep = 0;
      tick = m_lv && (m_run == 0) && smp;
      if (smp != m_lv) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lv  = smp;
          m_run = 0;
          if (smp) m_rise = 1;
          else begin
            m_fall  = 1;
            m_ticks = 0;
          end
        end
      end else begin
        m_run = 0;
      end
      if (tick) begin
        m_ticks++;
        if (REP_EN && m_ticks >= RDELAY && ((m_ticks - RDELAY) % RPER) == 0) m_rep = 1;
      end
    end
  end

  function automatic logic [3:0] model_vec();
    return {m_lv, m_rise, m_fall, m_rep};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int first_lv = 0;
    int n_rise   = 0;
    rst_n  = 1'b0;
    pb_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({lv_out, rise_pulse, fall_pulse, rep_pulse} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d got=%b want=0000", i, {lv_out, rise_pulse, fall_pulse, rep_pulse});
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      checks++;
      if ({lv_out, rise_pulse, fall_pulse, rep_pulse} !== model_vec()) begin
        errors++;
        $display("FAIL reset_model cyc%0d got=%b want=%b", i, {lv_out, rise_pulse, fall_pulse, rep_pulse}, model_vec());
      end
      if (lv_out === 1'b1 && first_lv == 0) first_lv = i;
      if (rise_pulse === 1'b1) n_rise++;
    end
    checks++;
    if (first_lv != D + 3) begin
      errors++;
      $display("FAIL reset_rise_latency got=%0d want=%0d", first_lv, D + 3);
    end
    checks++;
    if (n_rise != 1) begin
      errors++;
      $display("FAIL reset_rise_count got=%0d want=1", n_rise);
    end
  endtask

  task automatic test_bounce();
    int n_pulse = 0;
    int n_lv    = 0;
    pb_raw = 1'b0;
    for (int i = 0; i < D + 8; i++) step();
    for (int i = 0; i < 230; i++) begin
      pb_raw = (i < 200) ? ((i / 5) % 2 == 0) : 1'b0;
      step();
      checks++;
      if ({lv_out, rise_pulse, fall_pulse, rep_pulse} !== model_vec()) begin
        errors++;
        $display("FAIL bounce_model cyc%0d got=%b want=%b", i, {lv_out, rise_pulse, fall_pulse, rep_pulse}, model_vec());
      end
      if (rise_pulse || fall_pulse || rep_pulse) n_pulse++;
      if (lv_out) n_lv++;
    end
    checks++;
    if (n_pulse != 0 || n_lv != 0) begin
      errors++;
      $display("FAIL bounce_quiet pulses=%0d lv_high=%0d want 0/0", n_pulse, n_lv);
    end
  endtask

  task automatic test_glitch();
    int n_fall  = 0;
    int lv_drop = 0;
    for (int i = 1; i <= 158; i++) begin
      pb_raw = !(i > 100 && i <= 108);
      step();
      checks++;
      if ({lv_out, rise_pulse, fall_pulse, rep_pulse} !== model_vec()) begin
        errors++;
        $display("FAIL glitch_model cyc%0d got=%b want=%b", i, {lv_out, rise_pulse, fall_pulse, rep_pulse}, model_vec());
      end
      if (fall_pulse) n_fall++;
      if (i > D + 3 && lv_out !== 1'b1) lv_drop++;
    end
    checks++;
    if (n_fall != 0 || lv_drop != 0) begin
      errors++;
      $display("FAIL glitch_hold falls=%0d lv_low_cycles=%0d want 0/0", n_fall, lv_drop);
    end
  endtask

  task automatic test_fall();
    int n_fall = 0;
    int at     = 0;
    pb_raw = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      checks++;
      if ({lv_out, rise_pulse, fall_pulse, rep_pulse} !== model_vec()) begin
        errors++;
        $display("FAIL fall_model cyc%0d got=%b want=%b", i, {lv_out, rise_pulse, fall_pulse, rep_pulse}, model_vec());
      end
      if (fall_pulse === 1'b1) begin
        n_fall++;
        at = i;
      end
    end
    checks++;
    if (n_fall != 1 || at != D + 3) begin
      errors++;
      $display("FAIL fall_once count=%0d at=%0d want 1 at %0d", n_fall, at, D + 3);
    end
    checks++;
    if (lv_out !== 1'b0) begin
      errors++;
      $display("FAIL fall_level got=%b want=0", lv_out);
    end
  endtask

  task automatic test_reset_mid();
    int first_lv = 0;
    pb_raw = 1'b1;
    for (int i = 0; i < 13; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lv_out, rise_pulse, fall_pulse, rep_pulse} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_clear got=%b want=0000", {lv_out, rise_pulse, fall_pulse, rep_pulse});
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      checks++;
      if ({lv_out, rise_pulse, fall_pulse, rep_pulse} !== model_vec()) begin
        errors++;
        $display("FAIL midreset_model cyc%0d got=%b want=%b", i, {lv_out, rise_pulse, fall_pulse, rep_pulse}, model_vec());
      end
      if (lv_out === 1'b1 && first_lv == 0) first_lv = i;
    end
    checks++;
    if (first_lv != D + 3) begin
      errors++;
      $display("FAIL midreset_latency got=%0d want=%0d", first_lv, D + 3);
    end
  endtask

  task automatic test_autorepeat();
    int rise_at = 0;
    int last    = 0;
    int n_rep   = 0;
    int bad_gap = 0;
    pb_raw = 1'b0;
    for (int i = 0; i < D + 8; i++) step();
    pb_raw = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      step();
      checks++;
      if ({lv_out, rise_pulse, fall_pulse, rep_pulse} !== model_vec()) begin
        errors++;
        $display("FAIL repeat_model cyc%0d got=%b want=%b", i, {lv_out, rise_pulse, fall_pulse, rep_pulse}, model_vec());
      end
      if (rise_pulse === 1'b1) rise_at = i;
      if (rep_pulse === 1'b1) begin
        n_rep++;
        if (n_rep == 1 && i - rise_at != RDELAY) bad_gap++;
        if (n_rep > 1 && i - last != RPER) bad_gap++;
        last = i;
      end
    end
    checks++;
    if (REP_EN) begin
      int want = (200 - (D + 3) - RDELAY) / RPER + 1;
      if (n_rep != want || bad_gap != 0) begin
        errors++;
        $display("FAIL repeat_spacing reps=%0d bad_gaps=%0d want %0d/0", n_rep, bad_gap, want);
      end
    end else if (n_rep != 0) begin
      errors++;
      $display("FAIL repeat_disabled reps=%0d want=0", n_rep);
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    while (cyc < 2500) begin
      int len = $urandom_range(1, 45);
      pb_raw = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        step();
        cyc++;
        checks++;
        if ({lv_out, rise_pulse, fall_pulse, rep_pulse} !== model_vec()) begin
          errors++;
          $display("FAIL random_model cyc%0d got=%b want=%b", cyc, {lv_out, rise_pulse, fall_pulse, rep_pulse}, model_vec());
        end
        checks++;
        if (rise_pulse && fall_pulse) begin
          errors++;
          $display("FAIL random_exclusive cyc%0d rise=1 fall=1 want not both", cyc);
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    pb_raw = 1'b0;
    test_reset();
    test_bounce();
    test_glitch();
    test_fall();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
